// File: rtl/booth_mul_sched.sv
// Radix-2 Booth sequential multiplier shared by two requesters through a
// round-robin front end. Ports: req0/req1 valid/ready + operands, res valid/ready + product/id, busy.
module booth_mul_sched #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_m,
  input  logic [WIDTH-1:0]   req0_q,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_m,
  input  logic [WIDTH-1:0]   req1_q,
  output logic               req1_ready,
  output logic               res_valid,
  output logic [2*WIDTH-1:0] res_z,
  output logic               res_id,
  input  logic               res_ready,
  output logic               busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH-1:0] qr_q, qr_d;
  logic             q1_q, q1_d;
  logic             id_q, id_d;

  logic             gnt0, gnt1;
  logic [WIDTH-1:0] sel_m, sel_q;
  logic [WIDTH:0]   sum;

  // prio==0 favours requester 0 on a tie; a lone requester always wins
  always_comb begin
    gnt1 = req1_valid && (!req0_valid || prio_q);
    gnt0 = req0_valid && !gnt1;
  end

  assign req0_ready = (state_q == IDLE) && gnt0;
  assign req1_ready = (state_q == IDLE) && gnt1;
  assign sel_m      = gnt1 ? req1_m : req0_m;
  assign sel_q      = gnt1 ? req1_q : req0_q;

  assign res_valid  = (state_q == DONE);
  assign res_z      = {a_q[WIDTH-1:0], qr_q};
  assign res_id     = id_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    sum = a_q;
    unique case ({qr_q[0], q1_q})
      2'b01:   sum = a_q + m_q;
      2'b10:   sum = a_q - m_q;
      default: sum = a_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    m_d     = m_q;
    qr_d    = qr_q;
    q1_d    = q1_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          m_d     = {sel_m[WIDTH-1], sel_m};
          a_d     = '0;
          qr_d    = sel_q;
          q1_d    = 1'b0;
          cnt_d   = '0;
          id_d    = gnt1;
          state_d = STEP;
        end
      end
      STEP: begin
        // arithmetic right shift of {A, Q, q_1} after the add/sub
        {a_d, qr_d, q1_d} = {sum[WIDTH], sum, qr_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          prio_d  = ~id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      m_q     <= '0;
      qr_q    <= '0;
      q1_q    <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      m_q     <= m_d;
      qr_q    <= qr_d;
      q1_q    <= q1_d;
      id_q    <= id_d;
    end
  end

endmodule

// File: tb/tb_booth_mul_sched.sv
// Scoreboard bench for booth_mul_sched: handshakes push expected products,
// a negedge monitor pops and checks value, id and latency.
module tb_booth_mul_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_m, req0_q, req1_m, req1_q;
  logic       req0_ready, req1_ready;
  logic       res_valid, res_id, res_ready, busy;
  logic [7:0] res_z;

  booth_mul_sched #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_m(req0_m), .req0_q(req0_q),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_m(req1_m), .req1_q(req1_q),
    .req1_ready(req1_ready),
    .res_valid(res_valid), .res_z(res_z), .res_id(res_id),
    .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [7:0] z;
    int         hs;
  } exp_t;

  exp_t       sb[$];
  bit         gl[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_z0, exp_z1;
  bit         vseen = 0;
  int         drv_done = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      vseen = 0;
    end else begin
      if (req0_valid && req0_ready) begin
        sb.push_back('{1'b0, exp_z0, cyc + 1});
        gl.push_back(1'b0);
      end
      if (req1_valid && req1_ready) begin
        sb.push_back('{1'b1, exp_z1, cyc + 1});
        gl.push_back(1'b1);
      end
      if (res_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_result actual=%0h required=none", res_z);
        end else begin
          if (!vseen) chk("latency", cyc, sb[0].hs + 4);
          vseen = 1;
          if (res_ready) begin
            exp_t e;
            e = sb.pop_front();
            chk("res_z", res_z, e.z);
            chk("res_id", res_id, e.id);
            vseen = 0;
          end
        end
      end
    end
  end

  task automatic issue(input bit p, input logic [3:0] m, input logic [3:0] q,
                       input logic [7:0] ez);
    bit done = 0;
    if (!p) begin
      req0_m = m; req0_q = q; exp_z0 = ez; req0_valid = 1'b1;
    end else begin
      req1_m = m; req1_q = q; exp_z1 = ez; req1_valid = 1'b1;
    end
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!p && req0_valid && req0_ready) done = 1;
      if (p && req1_valid && req1_ready) done = 1;
    end
    if (!done) chk("hs_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!p) req0_valid = 1'b0;
    else    req1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (sb.size() != 0 || busy); i++) @(negedge clk);
    chk("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_drv(input bit p, input int n);
    logic [3:0] m, q;
    int         pr;
    for (int k = 0; k < n; k++) begin
      m  = 4'($urandom);
      q  = 4'($urandom);
      pr = int'($signed(m)) * int'($signed(q));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      issue(p, m, q, pr[7:0]);
    end
    drv_done++;
  endtask

  logic [3:0] vm[7] = '{4'd4, 4'd7, 4'd7, 4'b1010, 4'b1000, 4'd0, 4'b1000};
  logic [3:0] vq[7] = '{4'd6, 4'd7, 4'b1011, 4'b1010, 4'b1000, 4'b1000, 4'd7};
  logic [7:0] vz[7] = '{8'h18, 8'h31, 8'hDD, 8'h24, 8'h40, 8'h00, 8'hC8};

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_m = 0; req0_q = 0; req1_m = 0; req1_q = 0;
    res_ready = 1'b1;
    exp_z0 = 0; exp_z1 = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_z", res_z, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      issue(0, vm[i], vq[i], vz[i]);
      drain();
    end

    do_reset();
    gl.delete();
    fork
      begin
        for (int k = 0; k < 3; k++) issue(0, 4'd3, 4'd5, 8'h0F);
      end
      begin
        for (int k = 0; k < 3; k++) issue(1, 4'd2, 4'b1101, 8'hFA);
      end
    join
    drain();
    chk("grant_count", gl.size(), 6);
    if (gl.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("grant_order", gl[i], i % 2);
    end

    res_ready = 1'b0;
    issue(0, 4'd5, 4'b1110, 8'hF6);
    req1_m = 4'd1; req1_q = 4'd1; exp_z1 = 8'h01; req1_valid = 1'b1;
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (res_valid) seen = 1;
      end
      if (!seen) chk("bp_timeout", 0, 1);
      for (int i = 0; i < 10; i++) begin
        if (i > 0) @(negedge clk);
        chk("bp_z", res_z, 8'hF6);
        chk("bp_id", res_id, 0);
        chk("bp_busy", busy, 1);
        chk("bp_valid", res_valid, 1);
        chk("bp_rdy", {req0_ready, req1_ready}, 0);
      end
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    issue(1, 4'd1, 4'd1, 8'h01);
    drain();

    issue(0, 4'd2, 4'd3, 8'h06);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_z", res_z, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(0, 4'hF, 4'hF, 8'h01);
    drain();

    fork
      rand_drv(0, 500);
      rand_drv(1, 500);
      begin
        while (drv_done < 2) begin
          @(posedge clk);
          #1;
          res_ready = 1'($urandom);
        end
        res_ready = 1'b1;
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
